// File: rtl/mmio_uart_pkg.sv
// Shared constants and types for the memory-mapped UART transmitter:
// register offsets inside the window, STATUS bit positions and FSM states.
package mmio_uart_pkg;

    localparam logic [3:0] UART_TXDATA_OFF  = 4'h0;
    localparam logic [3:0] UART_STATUS_OFF  = 4'h4;
    localparam logic [3:0] UART_DIVISOR_OFF = 4'h8;

    localparam int STATUS_FULL_BIT     = 0;
    localparam int STATUS_EMPTY_BIT    = 1;
    localparam int STATUS_BUSY_BIT     = 2;
    localparam int STATUS_OVERFLOW_BIT = 3;
    localparam int STATUS_COUNT_LSB    = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_tx_state_t;

endpackage

// File: rtl/uart_fifo.sv
// Small synchronous FIFO for TX bytes. Pointers carry one extra wrap bit so
// full and empty are distinguishable without a separate counter register.
module uart_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count    = wr_ptr - rd_ptr;
    assign do_pop   = pop && !empty;
    // A push into a full FIFO is allowed when a pop frees the slot that same cycle.
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Bus-attached UART transmitter: register decode, STATUS/DIVISOR registers,
// TX FIFO and an 8N1 serialiser driven by a per-frame latched baud divisor.
module mmio_uart_tx
    import mmio_uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'hFFFF_FFE0,
    parameter logic [15:0] DEFAULT_DIV = 16'd104,
    parameter int          FIFO_DEPTH  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        write_mem,
    input  logic [31:0] write_address,
    input  logic [31:0] write_data,
    input  logic [2:0]  funct3,
    input  logic [31:0] read_address,
    output logic [31:0] read_data,
    output logic        read_hit,
    output logic        tx
);
    localparam int          CW           = $clog2(FIFO_DEPTH) + 1;
    localparam logic [29:0] BASE_WORD    = BASE_ADDR[31:2];
    localparam logic [29:0] TXDATA_WORD  = {28'd0, UART_TXDATA_OFF[3:2]};
    localparam logic [29:0] STATUS_WORD  = {28'd0, UART_STATUS_OFF[3:2]};
    localparam logic [29:0] DIVISOR_WORD = {28'd0, UART_DIVISOR_OFF[3:2]};

    uart_tx_state_t state;
    logic [29:0]    wr_word;
    logic [29:0]    rd_word;
    logic           txdata_wr;
    logic           status_wr;
    logic           divisor_wr;
    logic [15:0]    divisor;
    logic [15:0]    div_latched;
    logic [15:0]    baud_cnt;
    logic [2:0]     bit_cnt;
    logic [7:0]     shift;
    logic           overflow;
    logic           baud_done;
    logic           pop;
    logic           fifo_full;
    logic           fifo_empty;
    logic [7:0]     fifo_data;
    logic [CW-1:0]  fifo_count;
    logic [31:0]    status_word;
    logic           unused_bits;

    // Offsets are relative word indices; addresses below the base wrap high and miss.
    assign wr_word     = write_address[31:2] - BASE_WORD;
    assign rd_word     = read_address[31:2] - BASE_WORD;
    assign txdata_wr   = write_mem && (wr_word == TXDATA_WORD);
    assign status_wr   = write_mem && (wr_word == STATUS_WORD);
    assign divisor_wr  = write_mem && (wr_word == DIVISOR_WORD) && (funct3 == 3'b010);
    assign unused_bits = ^{write_address[1:0], read_address[1:0], write_data[31:16]};

    assign baud_done = (baud_cnt == div_latched - 16'd1);
    assign pop       = !fifo_empty && ((state == IDLE) || ((state == STOP) && baud_done));

    uart_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (txdata_wr),
        .push_data (write_data[7:0]),
        .pop       (pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        status_word                              = '0;
        status_word[STATUS_FULL_BIT]             = fifo_full;
        status_word[STATUS_EMPTY_BIT]            = fifo_empty;
        status_word[STATUS_BUSY_BIT]             = (state != IDLE);
        status_word[STATUS_OVERFLOW_BIT]         = overflow;
        status_word[STATUS_COUNT_LSB +: CW]      = fifo_count;
    end

    // Software-visible registers; a new overflow outranks a same-cycle clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            divisor  <= DEFAULT_DIV;
            overflow <= 1'b0;
        end else begin
            if (divisor_wr)
                divisor <= (write_data[15:0] < 16'd2) ? 16'd2 : write_data[15:0];
            if (txdata_wr && fifo_full && !pop)
                overflow <= 1'b1;
            else if (status_wr && write_data[STATUS_OVERFLOW_BIT])
                overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            read_data <= '0;
            read_hit  <= 1'b0;
        end else begin
            read_hit <= (rd_word < 30'd3);
            case (rd_word)
                STATUS_WORD:  read_data <= status_word;
                DIVISOR_WORD: read_data <= {16'd0, divisor};
                default:      read_data <= '0;
            endcase
        end
    end

    // Serialiser: every state lasts div_latched cycles; a frame is reloaded from
    // the FIFO straight out of STOP so consecutive bytes have no idle gap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            tx          <= 1'b1;
            baud_cnt    <= '0;
            bit_cnt     <= '0;
            shift       <= '0;
            div_latched <= DEFAULT_DIV;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        state       <= START;
                        tx          <= 1'b0;
                        shift       <= fifo_data;
                        div_latched <= divisor;
                        baud_cnt    <= '0;
                    end
                end
                START: begin
                    if (baud_done) begin
                        state    <= DATA;
                        tx       <= shift[0];
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            shift   <= shift >> 1;
                            tx      <= shift[1];
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        if (pop) begin
                            state       <= START;
                            tx          <= 1'b0;
                            shift       <= fifo_data;
                            div_latched <= divisor;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx: stimulus queues expected reads and frames,
// independent monitors compare bus reads and every tx cycle against them.
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE = 32'hFFFF_FFE0;
    localparam logic [31:0] A_TXDATA  = BASE + 32'd0;
    localparam logic [31:0] A_STATUS  = BASE + 32'd4;
    localparam logic [31:0] A_DIVISOR = BASE + 32'd8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        write_mem = 1'b0;
    logic [31:0] write_address = '0;
    logic [31:0] write_data = '0;
    logic [2:0]  funct3 = '0;
    logic [31:0] read_address = '0;
    logic [31:0] read_data;
    logic        read_hit;
    logic        tx;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [7:0] data;
        int         div;
        bit         immediate;
    } frame_t;

    frame_t      frame_q[$];
    logic [31:0] read_q[$];
    string       read_name_q[$];
    bit          in_frame = 1'b0;

    logic [7:0] burst_bytes [9] = '{8'h01, 8'h80, 8'h3C, 8'hC3, 8'hFF,
                                    8'h00, 8'h5A, 8'h96, 8'h7E};

    mmio_uart_tx dut (
        .clk           (clk),
        .reset         (reset),
        .write_mem     (write_mem),
        .write_address (write_address),
        .write_data    (write_data),
        .funct3        (funct3),
        .read_address  (read_address),
        .read_data     (read_data),
        .read_hit      (read_hit),
        .tx            (tx)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data,
                                 input logic [2:0] f3);
        write_mem     = 1'b1;
        write_address = addr;
        write_data    = data;
        funct3        = f3;
        @(posedge clk);
        #1;
        write_mem = 1'b0;
    endtask

    task automatic pushByte(input logic [7:0] b, input int div, input bit imm);
        frame_t f;
        f.data      = b;
        f.div       = div;
        f.immediate = imm;
        frame_q.push_back(f);
        applyStimulus(A_TXDATA, {24'd0, b}, 3'b000);
    endtask

    task automatic readReg(input logic [31:0] addr, input logic [31:0] expected,
                           input string name);
        read_q.push_back(expected);
        read_name_q.push_back(name);
        read_address = addr;
        @(posedge clk);
        #1;
        read_address = '0;
    endtask

    task automatic waitDone(input int budget, input string name);
        int n = 0;
        while ((frame_q.size() != 0 || in_frame) && n < budget) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        checkOutput({name, "_frames_pending"},
                    32'((frame_q.size() != 0 || in_frame) ? 1 : 0), 32'd0);
    endtask

    // Read monitor: every registered hit consumes one expected value.
    initial begin
        forever begin
            @(negedge clk);
            if (read_hit) begin
                if (read_q.size() == 0)
                    checkOutput("read_unexpected_hit", 32'd1, 32'd0);
                else
                    checkOutput(read_name_q.pop_front(), read_data, read_q.pop_front());
            end
        end
    end

    // Frame monitor: checks tx on every cycle of each expected frame.
    initial begin
        frame_t e;
        bit     cont;
        int     total;
        int     bi;
        int     idle_n;
        logic   exp_bit;
        forever begin
            @(negedge clk);
            if (reset && tx == 1'b0) begin
                cont = 1'b1;
                while (cont) begin
                    cont = 1'b0;
                    if (frame_q.size() == 0) begin
                        checkOutput("unexpected_frame", 32'd1, 32'd0);
                        idle_n = 0;
                        while (tx == 1'b0 && idle_n < 5000) begin
                            @(negedge clk);
                            idle_n++;
                        end
                    end else begin
                        e        = frame_q.pop_front();
                        in_frame = 1'b1;
                        total    = 10 * e.div;
                        for (int k = 0; k < total; k++) begin
                            if (k != 0) @(negedge clk);
                            if (!reset) break;
                            bi = k / e.div;
                            if (bi == 0)      exp_bit = 1'b0;
                            else if (bi == 9) exp_bit = 1'b1;
                            else              exp_bit = e.data[bi-1];
                            checkOutput($sformatf("tx_byte%02h_bit%0d_cyc%0d", e.data, bi, k % e.div),
                                        {31'd0, tx}, {31'd0, exp_bit});
                        end
                        in_frame = 1'b0;
                        if (reset && frame_q.size() != 0 && frame_q[0].immediate) begin
                            @(negedge clk);
                            checkOutput("b2b_start_no_gap", {31'd0, tx}, 32'd0);
                            cont = (tx == 1'b0);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got timeout, expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        // Reset values while held in reset, then release.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_tx", {31'd0, tx}, 32'd1);
        checkOutput("reset_read_hit", {31'd0, read_hit}, 32'd0);
        checkOutput("reset_read_data", read_data, 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        readReg(A_STATUS, 32'h0000_0002, "status_after_reset");
        readReg(A_DIVISOR, 32'd104, "divisor_default");
        readReg(A_TXDATA, 32'd0, "txdata_reads_zero");
        read_address = BASE + 32'd12;
        @(posedge clk);
        #1;
        checkOutput("outside_window_hit", {31'd0, read_hit}, 32'd0);
        checkOutput("outside_window_data", read_data, 32'd0);
        read_address = '0;

        // Single frame at divisor 4, with write-to-start latency and busy.
        applyStimulus(A_DIVISOR, 32'd4, 3'b010);
        applyStimulus(A_DIVISOR, 32'd7, 3'b000);
        readReg(A_DIVISOR, 32'd4, "divisor_byte_write_ignored");
        pushByte(8'hA5, 4, 1'b0);
        checkOutput("tx_idle_on_write_edge", {31'd0, tx}, 32'd1);
        @(posedge clk);
        #1;
        checkOutput("tx_low_on_pop_edge", {31'd0, tx}, 32'd0);
        readReg(A_STATUS, 32'h0000_0006, "status_busy_mid_frame");
        waitDone(100, "single");
        readReg(A_STATUS, 32'h0000_0002, "status_idle_after_frame");

        // Fill the FIFO, overflow on the tenth push, then clear it.
        for (int i = 0; i < 9; i++)
            pushByte(burst_bytes[i], 4, (i != 0));
        applyStimulus(A_TXDATA, 32'h0000_00EE, 3'b000);
        readReg(A_STATUS, 32'h0000_080D, "status_full_overflow");
        applyStimulus(A_STATUS, 32'h0000_0008, 3'b010);
        readReg(A_STATUS, 32'h0000_0805, "status_overflow_cleared");
        waitDone(500, "burst");
        readReg(A_STATUS, 32'h0000_0002, "status_after_burst");

        // Back-to-back frames at divisor 2.
        applyStimulus(A_DIVISOR, 32'd2, 3'b010);
        pushByte(8'h55, 2, 1'b0);
        pushByte(8'hFF, 2, 1'b1);
        pushByte(8'h0F, 2, 1'b1);
        readReg(A_STATUS, 32'h0000_0204, "status_count_two");
        repeat (39) @(posedge clk);
        #1;
        readReg(A_STATUS, 32'h0000_0006, "status_count_zero_last_frame");
        waitDone(100, "b2b");

        // Divisor change mid-frame applies from the next frame, clamped to 2.
        applyStimulus(A_DIVISOR, 32'd4, 3'b010);
        pushByte(8'h3C, 4, 1'b0);
        pushByte(8'hA7, 2, 1'b1);
        applyStimulus(A_DIVISOR, 32'd1, 3'b010);
        readReg(A_DIVISOR, 32'd2, "divisor_clamped");
        waitDone(100, "div_change");

        // Asynchronous reset during DATA truncates the frame and flushes the FIFO.
        applyStimulus(A_DIVISOR, 32'd8, 3'b010);
        pushByte(8'h00, 8, 1'b0);
        applyStimulus(A_TXDATA, 32'h0000_0077, 3'b000);
        repeat (11) @(posedge clk);
        #1;
        checkOutput("tx_low_in_data", {31'd0, tx}, 32'd0);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("tx_high_async_reset", {31'd0, tx}, 32'd1);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        readReg(A_STATUS, 32'h0000_0002, "status_after_mid_frame_reset");
        readReg(A_DIVISOR, 32'd104, "divisor_after_mid_frame_reset");
        repeat (20) @(posedge clk);
        #1;
        checkOutput("tx_idle_after_reset", {31'd0, tx}, 32'd1);

        checkOutput("read_queue_drained", 32'(read_q.size()), 32'd0);
        checkOutput("frame_queue_drained", 32'(frame_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
